// File: rtl/pipe_reg.sv
// pipe_reg: elastic DEPTH-stage, WIDTH-bit register pipeline with valid/ready on both ends,
// bubble collapsing and occupancy count. Define PIPE_REG_FLUSH_EN to add a synchronous flush input.
module pipe_reg #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef PIPE_REG_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r    [DEPTH];
    logic [CW-1:0]    count_r;
    logic [DEPTH:0]   rdy_s;
    logic             rdy_acc_s;
    logic [DEPTH-1:0] stage_v_s;
    logic [WIDTH-1:0] stage_d_s [DEPTH];
    logic             flush_s;
    logic             push_s;
    logic             pop_s;

`ifdef PIPE_REG_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Ready chain: a stage can load when it is empty or the stage ahead is moving.
    always_comb begin
        rdy_acc_s    = out_ready;
        rdy_s        = '0;
        rdy_s[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_acc_s = ~valid_r[i] | rdy_acc_s;
            rdy_s[i]  = rdy_acc_s;
        end
    end

    // Per-stage incoming valid/data: stage 0 from upstream, others from the stage behind.
    always_comb begin
        stage_v_s[0] = in_valid;
        stage_d_s[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            stage_v_s[i] = valid_r[i-1];
            stage_d_s[i] = data_r[i-1];
        end
    end

    assign in_ready = rdy_s[0] & ~rst & ~flush_s;
    assign push_s   = in_valid & in_ready;
    assign pop_s    = valid_r[DEPTH-1] & out_ready;

    // Valid bits and occupancy counter; reset beats flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            count_r <= '0;
        end else if (flush_s) begin
            valid_r <= '0;
            count_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy_s[i]) begin
                    valid_r[i] <= stage_v_s[i];
                end
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Data registers load only real items, so a stalled stage keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= RESET_VAL;
            end
        end else if (!flush_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy_s[i] && stage_v_s[i]) begin
                    data_r[i] <= stage_d_s[i];
                end
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
    assign count     = count_r;

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5) using a queue-of-items
// model; the flush scenario runs only when PIPE_REG_FLUSH_EN is defined.
module tb_pipe_reg;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       flush = 1'b0;

    pipe_reg #(.WIDTH(8), .DEPTH(DEPTH), .RESET_VAL(8'hA5)) dut (
        .clk(clk),
        .rst(rst),
`ifdef PIPE_REG_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    // Model: items in arrival order with their stage position (DEPTH-1 = output stage).
    logic [7:0] m_q[$];
    int         m_p[$];
    logic [7:0] popped[$];
    bit         known = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       s_ir, s_ov;
    logic [7:0] s_od;
    logic [2:0] s_cnt;
    int         first;
    int         nxt;
    logic       ir_k4;

    function automatic bit m_in_ready();
        return !rst && !flush && (out_ready || m_q.size() < DEPTH);
    endfunction

    function automatic bit m_out_valid();
        return m_q.size() > 0 && m_p[0] == DEPTH - 1;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit push, pop;
        int bound, np;
        if (rst) begin
            m_q.delete();
            m_p.delete();
            known = 1'b1;
            return;
        end
        if (!known) return;
        if (flush) begin
            m_q.delete();
            m_p.delete();
            return;
        end
        push = in_valid && m_in_ready();
        pop  = m_out_valid() && out_ready;
        if (pop) begin
            popped.push_back(m_q[0]);
            void'(m_q.pop_front());
            void'(m_p.pop_front());
        end
        // Each item advances one stage unless blocked by the (already moved) item ahead.
        bound = DEPTH - 1;
        foreach (m_p[k]) begin
            np = m_p[k] + 1;
            if (np > bound) np = bound;
            m_p[k] = np;
            bound  = np - 1;
        end
        if (push) begin
            m_q.push_back(in_data);
            m_p.push_back(0);
        end
    endtask

    task automatic tick(input logic r, input logic iv, input logic [7:0] d,
                        input logic ordy, input logic fl);
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        #1;
        s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_cnt = count;
        if (known) begin
            chk("in_ready", in_ready, m_in_ready());
            chk("out_valid", out_valid, m_out_valid());
            chk("count", count, m_q.size());
            if (m_out_valid()) chk("out_data", out_data, m_q[0]);
        end
        @(posedge clk);
        model_update();
    endtask

    initial begin
        // Reset with in_valid high
        tick(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
        chk("rst_in_ready", s_ir, 0);
        tick(1'b1, 1'b1, 8'h12, 1'b1, 1'b0);
        chk("rst_out_valid", s_ov, 0);
        chk("rst_out_data", s_od, 8'hA5);
        chk("rst_count", s_cnt, 0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_in_ready", s_ir, 1);
        chk("post_rst_out_data", s_od, 8'hA5);

        // Streaming 1..10
        popped.delete();
        first = -1;
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, k < 10, 8'(k + 1), 1'b1, 1'b0);
            if (s_ov && first < 0) first = k;
            if (k == 6) chk("stream_count_mid", s_cnt, 4);
        end
        chk("stream_latency", first, 4);
        chk("stream_popped_n", popped.size(), 10);
        foreach (popped[i]) chk("stream_order", popped[i], i + 1);

        // Fill under stall: offer 1..6 with out_ready low
        popped.delete();
        nxt = 1;
        ir_k4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1, 8'(nxt), 1'b0, 1'b0);
            if (k == 4) ir_k4 = s_ir;
            if (s_ir) nxt++;
        end
        chk("stall_accepted", nxt - 1, 4);
        chk("stall_in_ready_after_full", ir_k4, 0);
        chk("stall_count", s_cnt, 4);
        chk("stall_out_valid", s_ov, 1);
        chk("stall_out_data", s_od, 1);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, nxt <= 6, 8'(nxt), 1'b1, 1'b0);
            if (s_ir && nxt <= 6) nxt++;
        end
        chk("stall_total_accepted", nxt - 1, 6);
        chk("stall_popped_n", popped.size(), 6);
        foreach (popped[i]) chk("stall_order", popped[i], i + 1);

        // Bubble collapse
        popped.delete();
        tick(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("bubble_count", s_cnt, 2);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bubble_first", s_od, 8'hAA);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bubble_second_valid", s_ov, 1);
        chk("bubble_second", s_od, 8'hBB);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bubble_empty", s_ov, 0);

        // Full pipeline with simultaneous push and pop
        popped.delete();
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 8'(8'h21 + k), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b1, 8'(8'h25 + k), 1'b1, 1'b0);
            chk("full_in_ready", s_ir, 1);
            chk("full_count", s_cnt, 4);
        end
        chk("full_pops", popped.size(), 5);
        for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_popped_n", popped.size(), 9);
        foreach (popped[i]) chk("full_order", popped[i], 8'h21 + i);

`ifdef PIPE_REG_FLUSH_EN
        // Flush at count 3 with an item offered
        popped.delete();
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 8'(8'h31 + k), 1'b0, 1'b0);
        tick(1'b0, 1'b1, 8'h34, 1'b0, 1'b1);
        chk("flush_in_ready", s_ir, 0);
        chk("flush_count_before", s_cnt, 3);
        tick(1'b0, 1'b1, 8'h35, 1'b1, 1'b0);
        chk("flush_count_after", s_cnt, 0);
        chk("flush_out_valid_after", s_ov, 0);
        first = -1;
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            if (s_ov && first < 0) first = k;
        end
        chk("flush_next_latency", first, 3);
        chk("flush_popped_n", popped.size(), 1);
        foreach (popped[i]) chk("flush_popped", popped[i], 8'h35);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

- Parametrised, elastic register pipeline: `DEPTH` stages of `WIDTH`-bit registers.
- Each stage carries a valid bit; a valid/ready handshake runs on both ends.
- Empty stages are filled by upstream data even when the output is stalled (bubble collapsing).
- Used as the general retiming/buffering stage between datapath blocks wherever the single-bit D flip-flop is too primitive: it adds width, depth, stall handling and occupancy reporting.

## Interface
Parameters:
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 4: number of register stages, ≥1.
- `RESET_VAL`, `'0`: value loaded into every data register on reset.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream has data.
- `in_ready` out 1: the pipeline accepts `in_data` this cycle.
- `in_data` in `WIDTH`: upstream data.
- `out_valid` out 1: the last stage holds valid data.
- `out_ready` in 1: downstream accepts `out_data` this cycle.
- `out_data` out `WIDTH`: data held in the last stage.
- `count` out `$clog2(DEPTH+1)`: number of valid stages, 0..`DEPTH`.
- `flush` in 1: present only with `PIPE_REG_FLUSH_EN`; see Configuration.

## Operation
- **Stage structure:** stage i (0 = input, `DEPTH`-1 = output) holds `v[i]` and `d[i]`.
- **Ready chain:**
  - `rdy[DEPTH]` = `out_ready`.
  - `rdy[i]` = `~v[i] | rdy[i+1]`.
  - `in_ready` = `rdy[0] & ~rst`. It is a combinational path from `out_ready`.
- **Stage 0:** when `rdy[0]` is high, it loads `v[0]` ← `in_valid` and `d[0]` ← `in_data`.
- **Stage i>0:** when `rdy[i]` is high, it loads `v[i]` ← `v[i-1]` and `d[i]` ← `d[i-1]`.
- **Data register enable:** `d[i]` loads only when `rdy[i]` is high and the incoming valid bit is 1. Otherwise it holds, so stale data never overwrites a stalled stage.
- **Outputs:** `out_valid` = `v[DEPTH-1]`, `out_data` = `d[DEPTH-1]`.
- **Handshakes:**
  - A transfer happens on either side when valid & ready are both high at a rising edge.
  - Upstream must hold `in_valid` and `in_data` stable until `in_ready`.
  - `out_data` and `out_valid` remain stable while `out_valid & ~out_ready`.
- **Occupancy:** `count` is a registered popcount of the valid bits, updated as `count + push − pop`.
  - push = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
- **Ordering:** order is preserved; no data is duplicated or dropped.
- **Full:** `count` = `DEPTH`, `in_ready` = `out_ready`. A simultaneous push and pop is allowed and `count` stays at `DEPTH`.
- **Empty:** `count` = 0, `out_valid` = 0, `in_ready` = 1.

## Timing
- **Reset** (`rst` high at an edge) forces, after that edge:
  - all `v[i]` = 0;
  - all `d[i]` = `RESET_VAL`;
  - `count` = 0;
  - therefore `out_valid` = 0 and `out_data` = `RESET_VAL`.
- **During reset:** `in_ready` = 0 while `rst` is high. Inputs are ignored and no handshake occurs in that cycle.
- **Reset mid-operation:** all in-flight data is discarded at the reset edge. Normal operation resumes on the first edge with `rst` low.
- **Latency:** an item accepted at edge t (pipeline empty, `out_ready` = 1) drives `out_valid` = 1 in the cycle after edge t+`DEPTH`−1, i.e. `DEPTH` cycles.
- **Throughput:** one item per cycle when unstalled. Zero-bubble stall/restart.
- **Stall propagation:** when `out_ready` drops, `in_ready` drops in the same cycle only if every stage is valid.

## Configuration
- **`PIPE_REG_FLUSH_EN` defined:**
  - Adds input port `flush` (1 bit, synchronous, active-high).
  - At an edge with `flush` high, all `v[i]` clear to 0 and `count` clears to 0.
  - `d[i]` are not cleared.
  - `in_ready` = 0 while `flush` is high, so no push occurs.
  - A pop in the flush cycle is still reported via `out_valid`, but the item is discarded regardless of `out_ready`.
  - `rst` has priority over `flush`.
- **`PIPE_REG_FLUSH_EN` undefined:** no `flush` port and no flush logic; behaviour as described above.

## Test plan
- **Reset:** `WIDTH`=8, `DEPTH`=4, `RESET_VAL`=8'hA5; assert `rst` for 2 cycles with `in_valid`=1 → `out_valid`=0, `out_data`=8'hA5, `count`=0, `in_ready`=0 during reset and 1 after.
- **Streaming:** with `out_ready`=1, push 1..10 on consecutive cycles → `out_valid` first high 4 cycles after the first push; outputs 1..10 on consecutive cycles; `count` steady at 4 mid-stream.
- **Fill under stall:** with `out_ready`=0, offer 1..6 → only 1..4 accepted; `in_ready`=0 from the cycle after the 4th push; `count`=4; `out_data`=1 held stable. Raise `out_ready` → 1..4 emerge, then 5 and 6 are accepted.
- **Bubble collapse:** with `out_ready`=0, push A, idle 2 cycles, push B → `count`=2, both in the top stages. Release → A then B on consecutive cycles.
- **Full push/pop:** at `count`=4 with `in_valid`=1 and `out_ready`=1 for 5 cycles → 5 transfers on each side; `count` stays 4; order preserved.
- **Flush** (`PIPE_REG_FLUSH_EN`): at `count`=3, pulse `flush` for 1 cycle with `in_valid`=1 → `count`=0, `out_valid`=0 next cycle; the offered item is not accepted; the next push emerges after 4 cycles.
